// File: rtl/capture_sequencer_if.sv
// Capture sequencer control/status bundle: arm/trigger controls and FIFO
// flags in, write strobe and capture status out.
interface capture_sequencer_if #(
  parameter int COUNT_WIDTH = 12
);
  logic                   arm;
  logic                   disarm;
  logic                   trigger;
  logic                   forceTrigger;
  logic                   autoRearm;
  logic [COUNT_WIDTH-1:0] recordLength;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic                   writeStrobe;
  logic [1:0]             state;
  logic [COUNT_WIDTH-1:0] samplesWritten;
  logic                   overflow;
  logic                   captureDone;
  logic [15:0]            triggerCount;

  modport slave (
    input  arm, disarm, trigger, forceTrigger, autoRearm, recordLength,
           fifoFull, fifoEmpty,
    output writeStrobe, state, samplesWritten, overflow, captureDone,
           triggerCount
  );

  modport master (
    output arm, disarm, trigger, forceTrigger, autoRearm, recordLength,
           fifoFull, fifoEmpty,
    input  writeStrobe, state, samplesWritten, overflow, captureDone,
           triggerCount
  );
endinterface

// File: rtl/capture_sequencer.sv
// ADC capture sequencer: arm, wait for trigger, strobe the FIFO write port for
// exactly the latched record length, then hold off until the FIFO drains.
module capture_sequencer #(
  parameter int COUNT_WIDTH = 12,
  parameter int DRAIN_MIN   = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  capture_sequencer_if.slave    bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_RECORD = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam int DLAST = (DRAIN_MIN > 1) ? DRAIN_MIN - 1 : 0;
  localparam int DW    = (DLAST > 0) ? $clog2(DLAST + 1) : 1;

  logic [1:0]             state_q, state_d;
  logic                   strobe_q, strobe_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] len_q, len_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;
  logic [15:0]            tcnt_q, tcnt_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic                   abort_q, abort_d;
  logic                   drain_ok;

  // FIFO empty flag is only trusted once its update latency has elapsed
  assign drain_ok = (dcnt_q == DW'(DLAST));

  always_comb begin
    state_d  = state_q;
    strobe_d = 1'b0;
    cnt_d    = cnt_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    tcnt_d   = tcnt_q;
    dcnt_d   = dcnt_q;
    abort_d  = abort_q;
    case (state_q)
      S_IDLE: begin
        if (bus.arm && !bus.disarm) begin
          state_d = S_ARMED;
          len_d   = (bus.recordLength == '0) ? COUNT_WIDTH'(1) : bus.recordLength;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_ARMED: begin
        if (bus.disarm) begin
          state_d = S_IDLE;
        end else if (bus.trigger || bus.forceTrigger) begin
          state_d  = S_RECORD;
          strobe_d = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
        end
      end
      S_RECORD: begin
        if (bus.fifoFull || bus.disarm || (cnt_q == len_q)) begin
          state_d = S_DRAIN;
          done_d  = 1'b1;
          dcnt_d  = '0;
          ovf_d   = ovf_q | bus.fifoFull;
          // an aborted capture must not re-arm after draining
          abort_d = !bus.fifoFull && bus.disarm;
        end else begin
          strobe_d = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: begin
        if (bus.disarm) abort_d = 1'b1;
        if (!drain_ok) dcnt_d = dcnt_q + 1'b1;
        if (drain_ok && bus.fifoEmpty) begin
          if (bus.autoRearm && !abort_q && !bus.disarm) begin
            state_d = S_ARMED;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      strobe_q <= 1'b0;
      cnt_q    <= '0;
      len_q    <= COUNT_WIDTH'(1);
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      tcnt_q   <= '0;
      dcnt_q   <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      tcnt_q   <= tcnt_d;
      dcnt_q   <= dcnt_d;
      abort_q  <= abort_d;
    end
  end

  assign bus.writeStrobe    = strobe_q;
  assign bus.state          = state_q;
  assign bus.samplesWritten = cnt_q;
  assign bus.overflow       = ovf_q;
  assign bus.captureDone    = done_q;
  assign bus.triggerCount   = tcnt_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: a per-cycle vector table followed by
// hand-written multi-cycle sequences.
module tb_capture_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  capture_sequencer_if #(.COUNT_WIDTH(12)) bus ();

  capture_sequencer #(.COUNT_WIDTH(12), .DRAIN_MIN(4)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // control bit order: {arm, disarm, trigger, forceTrigger, autoRearm, fifoFull, fifoEmpty}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_ARM  = 7'b1000000;
  localparam logic [6:0] C_DIS  = 7'b0100000;
  localparam logic [6:0] C_TRG  = 7'b0010000;
  localparam logic [6:0] C_FRC  = 7'b0001000;
  localparam logic [6:0] C_AR   = 7'b0000100;
  localparam logic [6:0] C_FULL = 7'b0000010;
  localparam logic [6:0] C_EMP  = 7'b0000001;

  typedef struct {
    logic [6:0]  ctl;
    logic [11:0] len;
    logic        strobe;
    logic [1:0]  st;
    logic [11:0] sw;
    logic        ovf;
    logic        done;
    logic [15:0] tc;
  } vec_t;

  vec_t vecs[21];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(input logic [6:0] ctl, input logic [11:0] len,
                             input logic strobe, input logic [1:0] st,
                             input logic [11:0] sw, input logic ovf,
                             input logic done, input logic [15:0] tc);
    vec_t r;
    r.ctl = ctl; r.len = len; r.strobe = strobe; r.st = st;
    r.sw = sw; r.ovf = ovf; r.done = done; r.tc = tc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic [6:0] ctl, input logic [11:0] len);
    {bus.arm, bus.disarm, bus.trigger, bus.forceTrigger, bus.autoRearm,
     bus.fifoFull, bus.fifoEmpty} = ctl;
    bus.recordLength = len;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic str, input logic [1:0] st,
                            input logic [11:0] sw, input logic ovf,
                            input logic dn, input logic [15:0] tc);
    chk({nm, ".writeStrobe"},    32'(bus.writeStrobe),    32'(str));
    chk({nm, ".state"},          32'(bus.state),          32'(st));
    chk({nm, ".samplesWritten"}, 32'(bus.samplesWritten), 32'(sw));
    chk({nm, ".overflow"},       32'(bus.overflow),       32'(ovf));
    chk({nm, ".captureDone"},    32'(bus.captureDone),    32'(dn));
    chk({nm, ".triggerCount"},   32'(bus.triggerCount),   32'(tc));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(C_NONE, 12'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = v(C_ARM,         12'd3, 1'b0, 2'd1, 12'd0, 1'b0, 1'b0, 16'd0);
    vecs[1]  = v(C_ARM | C_TRG, 12'd5, 1'b1, 2'd2, 12'd1, 1'b0, 1'b0, 16'd1);
    vecs[2]  = v(C_NONE,        12'd0, 1'b1, 2'd2, 12'd2, 1'b0, 1'b0, 16'd1);
    vecs[3]  = v(C_TRG,         12'd0, 1'b1, 2'd2, 12'd3, 1'b0, 1'b0, 16'd1);
    vecs[4]  = v(C_NONE,        12'd0, 1'b0, 2'd3, 12'd3, 1'b0, 1'b1, 16'd1);
    vecs[5]  = v(C_EMP,         12'd0, 1'b0, 2'd3, 12'd3, 1'b0, 1'b0, 16'd1);
    vecs[6]  = v(C_EMP,         12'd0, 1'b0, 2'd3, 12'd3, 1'b0, 1'b0, 16'd1);
    vecs[7]  = v(C_EMP,         12'd0, 1'b0, 2'd3, 12'd3, 1'b0, 1'b0, 16'd1);
    vecs[8]  = v(C_EMP,         12'd0, 1'b0, 2'd0, 12'd3, 1'b0, 1'b0, 16'd1);
    vecs[9]  = v(C_ARM | C_DIS, 12'd7, 1'b0, 2'd0, 12'd3, 1'b0, 1'b0, 16'd1);
    vecs[10] = v(C_ARM | C_TRG, 12'd0, 1'b0, 2'd1, 12'd0, 1'b0, 1'b0, 16'd1);
    vecs[11] = v(C_NONE,        12'd0, 1'b0, 2'd1, 12'd0, 1'b0, 1'b0, 16'd1);
    vecs[12] = v(C_FRC,         12'd0, 1'b1, 2'd2, 12'd1, 1'b0, 1'b0, 16'd2);
    vecs[13] = v(C_NONE,        12'd0, 1'b0, 2'd3, 12'd1, 1'b0, 1'b1, 16'd2);
    vecs[14] = v(C_DIS | C_AR,  12'd0, 1'b0, 2'd3, 12'd1, 1'b0, 1'b0, 16'd2);
    vecs[15] = v(C_AR | C_EMP,  12'd0, 1'b0, 2'd3, 12'd1, 1'b0, 1'b0, 16'd2);
    vecs[16] = v(C_AR | C_EMP,  12'd0, 1'b0, 2'd3, 12'd1, 1'b0, 1'b0, 16'd2);
    vecs[17] = v(C_AR | C_EMP,  12'd0, 1'b0, 2'd0, 12'd1, 1'b0, 1'b0, 16'd2);
    vecs[18] = v(C_ARM,         12'd2, 1'b0, 2'd1, 12'd0, 1'b0, 1'b0, 16'd2);
    vecs[19] = v(C_DIS,         12'd0, 1'b0, 2'd0, 12'd0, 1'b0, 1'b0, 16'd2);
    vecs[20] = v(C_TRG,         12'd0, 1'b0, 2'd0, 12'd0, 1'b0, 1'b0, 16'd2);

    step(C_NONE, 12'd0);
    do_reset();
    expect_out("reset", 1'b0, 2'd0, 12'd0, 1'b0, 1'b0, 16'd0);

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].ctl, vecs[i].len);
      expect_out($sformatf("vec%0d", i), vecs[i].strobe, vecs[i].st, vecs[i].sw,
                 vecs[i].ovf, vecs[i].done, vecs[i].tc);
    end

    // Length-16 capture, trigger sampled at cycle 20, strobes in cycles 21..36
    do_reset();
    step(C_ARM, 12'd16);
    for (int c = 2; c < 20; c++) step(C_NONE, 12'd0);
    expect_out("len16.armed", 1'b0, 2'd1, 12'd0, 1'b0, 1'b0, 16'd0);
    step(C_TRG, 12'd0);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("len16.strobe%0d", i), 32'(bus.writeStrobe), 32'd1);
      chk($sformatf("len16.sw%0d", i), 32'(bus.samplesWritten), 32'(i));
      step(C_NONE, 12'd0);
    end
    expect_out("len16.done", 1'b0, 2'd3, 12'd16, 1'b0, 1'b1, 16'd1);
    for (int i = 0; i < 4; i++) step(C_EMP, 12'd0);
    expect_out("len16.idle", 1'b0, 2'd0, 12'd16, 1'b0, 1'b0, 16'd1);

    // fifoFull after 40 strobes of a 100-sample record
    do_reset();
    step(C_ARM, 12'd100);
    step(C_TRG, 12'd0);
    for (int i = 1; i < 40; i++) step(C_NONE, 12'd0);
    expect_out("full.pre", 1'b1, 2'd2, 12'd40, 1'b0, 1'b0, 16'd1);
    step(C_FULL, 12'd0);
    expect_out("full.cut", 1'b0, 2'd3, 12'd40, 1'b1, 1'b1, 16'd1);
    for (int i = 0; i < 4; i++) step(C_EMP, 12'd0);
    expect_out("full.idle", 1'b0, 2'd0, 12'd40, 1'b1, 1'b0, 16'd1);
    step(C_ARM, 12'd5);
    expect_out("full.rearm", 1'b0, 2'd1, 12'd0, 1'b0, 1'b0, 16'd1);

    // Auto re-arm over three captures; triggers during RECORD/DRAIN ignored
    do_reset();
    step(C_ARM | C_AR, 12'd2);
    for (int k = 1; k <= 3; k++) begin
      step(C_TRG | C_AR, 12'd0);
      expect_out($sformatf("auto%0d.rec1", k), 1'b1, 2'd2, 12'd1, 1'b0, 1'b0, 16'(k));
      step(C_TRG | C_AR, 12'd0);
      expect_out($sformatf("auto%0d.rec2", k), 1'b1, 2'd2, 12'd2, 1'b0, 1'b0, 16'(k));
      step(C_TRG | C_AR, 12'd0);
      expect_out($sformatf("auto%0d.drain", k), 1'b0, 2'd3, 12'd2, 1'b0, 1'b1, 16'(k));
      for (int i = 0; i < 3; i++) step(C_TRG | C_AR | C_EMP, 12'd0);
      chk($sformatf("auto%0d.hold", k), 32'(bus.state), 32'd3);
      step(C_TRG | C_AR | C_EMP, 12'd0);
      expect_out($sformatf("auto%0d.armed", k), 1'b0, 2'd1, 12'd0, 1'b0, 1'b0, 16'(k));
    end

    // Reset in the fifth strobe cycle of a 16-sample record
    do_reset();
    step(C_ARM, 12'd16);
    step(C_TRG, 12'd0);
    for (int i = 0; i < 4; i++) step(C_NONE, 12'd0);
    expect_out("rstmid.pre", 1'b1, 2'd2, 12'd5, 1'b0, 1'b0, 16'd1);
    rst = 1'b1;
    step(C_NONE, 12'd0);
    rst = 1'b0;
    expect_out("rstmid.rst", 1'b0, 2'd0, 12'd0, 1'b0, 1'b0, 16'd0);
    step(C_NONE, 12'd0);
    expect_out("rstmid.after", 1'b0, 2'd0, 12'd0, 1'b0, 1'b0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
